serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a one-bit sum/carry cell and a registered carry. It accepts two parallel operands on a start strobe and shifts them LSB-first through the cell, one bit per clock. It reassembles the sum, then presents the parallel sum and carry-out with a one-cycle done pulse. It sits upstream of wide arithmetic consumers where area matters more than latency.

## Interface

- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request to add A and B; sampled only when not busy.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; S and C valid from this cycle.
- S  output  WIDTH  sum (A+B) mod 2^WIDTH; held until the next completion.
- C  output  1  carry-out of bit WIDTH-1; held with S.

## Operation

- States: IDLE, ADD, DONE.
- Reset (rst=1 at a clock edge), from any state: state=IDLE, busy=0, done=0, S=0, C=0.
  - Also clears the operand shift registers, the sum shift register, the carry register and the bit counter.
- IDLE: start=1 is accepted.
  - Load a_sr=A and b_sr=B, set carry=0 and count=0.
  - Go to ADD.
- ADD, once per cycle:
  - bit = a_sr[0]^b_sr[0]^carry.
  - carry = (a_sr[0]&b_sr[0]) | (carry&(a_sr[0]^b_sr[0])).
  - Shift a_sr and b_sr right by one.
  - Shift the sum register right by one, with bit entering the MSB.
  - count increments.
  - On the cycle with count==WIDTH-1: write the final sum-register value (including this cycle's bit) to S and the updated carry to C, then go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE and goes straight to ADD.
  - Otherwise go to IDLE.
- start in ADD is ignored. No queuing; A and B changes during ADD have no effect.
- S and C change only on the ADD→DONE transition or on reset. They are never visible as partial values.
- Arithmetic is unsigned. Carry-out is the true bit WIDTH of A+B.

## Timing

- Edge k: start accepted (state IDLE or DONE).
- Edges k+1..k+WIDTH: WIDTH ADD cycles. busy=1 in the cycles after edges k through k+WIDTH-1.
- After edge k+WIDTH: state=DONE, done=1, busy=0, S and C valid. Latency is WIDTH+1 cycles from the start edge to the done cycle.
- Throughput: one addition per WIDTH+1 cycles when back-to-back starts are issued in DONE cycles.
- busy is registered and derived from state==ADD. done is registered and derived from state==DONE.
- rst asserted mid-ADD aborts the addition: no done pulse, and S and C return to 0.
  - A start in the same cycle as rst is ignored; rst wins.

## Test plan

- WIDTH=8, reset then A=0x0F, B=0x01, start one cycle → busy for 8 cycles; done at cycle 9 after the start edge; S=0x10, C=0.
- A=0xFF, B=0x01 → S=0x00, C=1. A=0xFF, B=0xFF → S=0xFE, C=1. A=0x00, B=0x00 → S=0x00, C=0.
- Start at the first cycle, then start=1 with A=0x01, B=0x01 during ADD cycles 3–5 → these are ignored; the first result is unchanged and no second done follows.
- start=1 in the DONE cycle with A=0x80, B=0x80 → no IDLE cycle, busy the next cycle; after the next done, S=0x00, C=1. The previous S/C is held until then.
- rst=1 during ADD cycle 4 → next cycle busy=0, done=0, S=0x00, C=0; no done pulse follows. A fresh start with 0x12+0x34 → S=0x46, C=0.
- Random regression, WIDTH=8 and WIDTH=16, 1000 operand pairs with random start gaps → {C,S} == A+B at every done; done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands shift LSB-first through a one-bit
// sum/carry cell, and the parallel sum plus carry-out appear with a done pulse.

module serial_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             sum_bit, carry_nxt;

  serial_add_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      C      <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= 1'b0;
            count <= '0;
            state <= ADD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ADD: begin
          carry  <= carry_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
          count  <= count + 1'b1;
          // The last bit is folded straight into S so no partial sum is ever visible.
          if (count == LAST) begin
            S     <= {sum_bit, sum_sr[WIDTH-1:1]};
            C     <= carry_nxt;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16; expected {C,S}
// values are queued at start and compared whenever done is seen.

module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        busy8, done8, c8, busy16, done16, c16;

  int checks = 0;
  int failures = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic        pd8 = 1'b0, pd16 = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .S(s8), .C(c8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .S(s16), .C(c16)
  );

  // Scoreboard monitors: every done must match the oldest queued result and last one cycle.
  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL done8_unexpected got S=%h C=%b with no pending add", s8, c8);
      end else begin
        logic [8:0] e8;
        e8 = q8.pop_front();
        if ({c8, s8} !== e8) begin
          failures++;
          $display("FAIL sum8 got {C,S}=%h expected %h", {c8, s8}, e8);
        end
      end
      checks++;
      if (pd8) begin
        failures++;
        $display("FAIL done8_width got 2+ cycles expected 1");
      end
    end
    pd8 = done8;
  end

  always @(negedge clk) begin
    if (done16) begin
      checks++;
      if (q16.size() == 0) begin
        failures++;
        $display("FAIL done16_unexpected got S=%h C=%b with no pending add", s16, c16);
      end else begin
        logic [16:0] e16;
        e16 = q16.pop_front();
        if ({c16, s16} !== e16) begin
          failures++;
          $display("FAIL sum16 got {C,S}=%h expected %h", {c16, s16}, e16);
        end
      end
      checks++;
      if (pd16) begin
        failures++;
        $display("FAIL done16_width got 2+ cycles expected 1");
      end
    end
    pd16 = done16;
  end

  task automatic start_8(input logic [7:0] a, input logic [7:0] b, input bit expect_done);
    start8 = 1'b1; a8 = a; b8 = b;
    if (expect_done) q8.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic start_16(input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; a16 = a; b16 = b;
    q16.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 60);
    checks++;
    if (!done8) begin
      failures++;
      $display("FAIL done8_timeout got no done in %0d cycles expected done", n);
    end
  endtask

  task automatic wait_done16();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done16 && n < 80);
    checks++;
    if (!done16) begin
      failures++;
      $display("FAIL done16_timeout got no done in %0d cycles expected done", n);
    end
  endtask

  task automatic no_done8(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL quiet8 got done=%b busy=%b expected 0/0", done8, busy8);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, c8, s8} !== 11'h0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b C=%b S=%h expected zeros", busy8, done8, c8, s8);
    end
    checks++;
    if ({busy16, done16, c16, s16} !== 19'h0) begin
      failures++;
      $display("FAIL reset16 got busy=%b done=%b C=%b S=%h expected zeros", busy16, done16, c16, s16);
    end
  endtask

  task automatic test_latency();
    start_8(8'h0F, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        failures++;
        $display("FAIL latency_busy cycle %0d got busy=%b done=%b expected 1/0", i + 1, busy8, done8);
      end
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL latency_done cycle 9 got done=%b busy=%b expected 1/0", done8, busy8);
    end
    no_done8(2);
  endtask

  task automatic test_corners();
    logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      start_8(ta[i], tb[i], 1'b1);
      wait_done8();
      no_done8(1);
    end
  endtask

  task automatic test_ignore_start();
    start_8(8'h3C, 8'h05, 1'b1);
    repeat (2) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    repeat (3) @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8();
    no_done8(12);
  endtask

  task automatic test_back_to_back();
    start_8(8'h55, 8'h0A, 1'b1);
    wait_done8();
    start_8(8'h80, 8'h80, 1'b1);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy got busy=%b expected 1", busy8);
    end
    checks++;
    if ({c8, s8} !== 9'h05F) begin
      failures++;
      $display("FAIL b2b_hold got {C,S}=%h expected 05f", {c8, s8});
    end
    wait_done8();
    no_done8(2);
  endtask

  task automatic test_reset_mid_add();
    start_8(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, c8, s8} !== 11'h0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b done=%b C=%b S=%h expected zeros", busy8, done8, c8, s8);
    end
    no_done8(12);
    start_8(8'h12, 8'h34, 1'b1);
    wait_done8();
    no_done8(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      start_8(8'($urandom), 8'($urandom), 1'b1);
      wait_done8();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      start_16(16'($urandom), 16'($urandom));
      wait_done16();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_add();
    test_random();
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      failures++;
      $display("FAIL pending got q8=%0d q16=%0d outstanding expected 0", q8.size(), q16.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
